// File: rtl/axi_lite_pkt_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkt_master
// Brief    : AXI-Lite write initiator. Issues one AW/W write per local request
//            and reports the B response (or a timeout) with a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_pkt_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    input  logic                  b_response,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic                  done_valid,
    output logic [1:0]            done_status,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  ok_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ERROR   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2
    } state_t;

    state_t                state_q,       state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q,     aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q,      w_data_d;
    logic                  aw_valid_q,    aw_valid_d;
    logic                  w_valid_q,     w_valid_d;
    logic                  b_ready_q,     b_ready_d;
    logic                  done_valid_q,  done_valid_d;
    logic [1:0]            done_status_q, done_status_d;
    logic [CNT_WIDTH-1:0]  ok_cnt_q,      ok_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q,     err_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q,     tmo_cnt_d;

    logic req_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic expired;
    logic aw_pending;
    logic w_pending;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign req_ready  = rst_n & (state_q == ST_IDLE);
    assign req_hs     = req_valid & req_ready;
    assign aw_hs      = aw_valid_q & aw_ready;
    assign w_hs       = w_valid_q & w_ready;
    assign b_hs       = b_ready_q & b_valid;
    assign expired    = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);
    // A channel is still outstanding only if its valid is up and not taken now.
    assign aw_pending = aw_valid_q & ~aw_ready;
    assign w_pending  = w_valid_q & ~w_ready;

    always_comb begin
        state_d       = state_q;
        aw_addr_d     = aw_addr_q;
        w_data_d      = w_data_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        b_ready_d     = b_ready_q;
        done_valid_d  = 1'b0;
        done_status_d = done_status_q;
        ok_cnt_d      = ok_cnt_q;
        err_cnt_d     = err_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    state_d    = ST_ISSUE;
                    aw_addr_d  = req_addr;
                    w_data_d   = req_data;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    tmo_cnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if (expired) begin
                    state_d       = ST_IDLE;
                    aw_valid_d    = 1'b0;
                    w_valid_d     = 1'b0;
                    b_ready_d     = 1'b0;
                    done_valid_d  = 1'b1;
                    done_status_d = STATUS_TIMEOUT;
                    err_cnt_d     = sat_inc(err_cnt_q);
                end else if (!aw_pending && !w_pending) begin
                    state_d   = ST_WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            ST_WAIT_B: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // A response landing on the expiry cycle takes precedence.
                if (b_hs) begin
                    state_d      = ST_IDLE;
                    b_ready_d    = 1'b0;
                    done_valid_d = 1'b1;
                    if (b_response) begin
                        done_status_d = STATUS_OK;
                        ok_cnt_d      = sat_inc(ok_cnt_q);
                    end else begin
                        done_status_d = STATUS_ERROR;
                        err_cnt_d     = sat_inc(err_cnt_q);
                    end
                end else if (expired) begin
                    state_d       = ST_IDLE;
                    b_ready_d     = 1'b0;
                    done_valid_d  = 1'b1;
                    done_status_d = STATUS_TIMEOUT;
                    err_cnt_d     = sat_inc(err_cnt_q);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                b_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= 2'b00;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            aw_addr_q     <= aw_addr_d;
            w_data_q      <= w_data_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            b_ready_q     <= b_ready_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign aw_addr     = aw_addr_q;
    assign w_data      = w_data_q;
    assign aw_valid    = aw_valid_q;
    assign w_valid     = w_valid_q;
    assign b_ready     = b_ready_q;
    assign done_valid  = done_valid_q;
    assign done_status = done_status_q;
    assign busy        = (state_q != ST_IDLE);
    assign ok_count    = ok_cnt_q;
    assign err_count   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_pkt_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_pkt_master
// Brief    : Randomized bench for axi_lite_pkt_master with a transaction-level
//            reference model of the slave timing and expected completion.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_pkt_master;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TMO     = 8;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] aw_addr;
    logic          aw_valid;
    logic          aw_ready = 1'b0;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready = 1'b0;
    logic          b_response = 1'b0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic          done_valid;
    logic [1:0]    done_status;
    logic          busy;
    logic [CW-1:0] ok_count;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    axi_lite_pkt_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .aw_addr     (aw_addr),
        .aw_valid    (aw_valid),
        .aw_ready    (aw_ready),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .b_response  (b_response),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .done_valid  (done_valid),
        .done_status (done_status),
        .busy        (busy),
        .ok_count    (ok_count),
        .err_count   (err_count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ok_m     = 0;
    int         err_m    = 0;
    logic [1:0] stat_m   = 2'b00;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue cycle is rel=0. The slave raises aw_ready from rel a_dly, w_ready
    // from rel w_dly, and pulses b_valid only at rel b_cyc.
    task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int a_dly, input int w_dly, input int b_cyc,
                           input logic resp);
        int         hs_max;
        int         exp_done;
        logic [1:0] exp_st;
        hs_max = (a_dly > w_dly) ? a_dly : w_dly;
        if (b_cyc >= hs_max + 1 && b_cyc <= TMO - 1) begin
            exp_done = b_cyc + 1;
            exp_st   = resp ? 2'b00 : 2'b01;
        end else begin
            exp_done = TMO;
            exp_st   = 2'b10;
        end

        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        tick();
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_data  = $urandom;

        for (int rel = 0; rel <= exp_done; rel++) begin
            if (rel < exp_done) begin
                chk("ctl", 64'({busy, done_valid, aw_valid, w_valid, b_ready, req_ready}),
                    64'({1'b1, 1'b0, rel <= a_dly, rel <= w_dly, rel >= hs_max + 1, 1'b0}));
                if (aw_valid) chk("aw_addr", 64'(aw_addr), 64'(addr));
                if (w_valid)  chk("w_data", 64'(w_data), 64'(data));
                chk("status_hold", 64'(done_status), 64'(stat_m));
                aw_ready   = (rel >= a_dly);
                w_ready    = (rel >= w_dly);
                b_valid    = (rel == b_cyc);
                b_response = (rel == b_cyc) ? resp : 1'($urandom);
                tick();
            end else begin
                if (exp_st == 2'b00) ok_m  = (ok_m  < CNT_MAX) ? ok_m + 1  : ok_m;
                else                 err_m = (err_m < CNT_MAX) ? err_m + 1 : err_m;
                stat_m = exp_st;
                chk("done_ctl", 64'({busy, done_valid, aw_valid, w_valid, b_ready, req_ready}),
                    64'(6'b010001));
                chk("done_status", 64'(done_status), 64'(exp_st));
                chk("ok_count", 64'(ok_count), 64'(ok_m));
                chk("err_count", 64'(err_count), 64'(err_m));
                aw_ready = 1'b0;
                w_ready  = 1'b0;
                b_valid  = 1'b0;
            end
        end
    endtask

    // Idle cycles with noise on the slave inputs, which must all be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            aw_ready   = 1'($urandom);
            w_ready    = 1'($urandom);
            b_valid    = 1'($urandom);
            b_response = 1'($urandom);
            tick();
            chk("idle_ctl", 64'({busy, done_valid, aw_valid, w_valid, b_ready, req_ready}),
                64'(6'b000001));
            chk("idle_status", 64'(done_status), 64'(stat_m));
        end
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
    endtask

    task automatic reset_mid_txn();
        chk("rst_pre_ready", 64'(req_ready), 64'd1);
        req_addr  = 8'h04;
        req_data  = 32'h0BAD_0BAD;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        aw_ready  = 1'b1;
        w_ready   = 1'b1;
        tick();
        chk("rst_in_wait_b", 64'({busy, b_ready, aw_valid, w_valid}), 64'(4'b1100));
        rst_n      = 1'b0;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b1;
        b_response = 1'b1;
        tick();
        ok_m   = 0;
        err_m  = 0;
        stat_m = 2'b00;
        chk("rst_outputs", 64'({aw_valid, w_valid, b_ready, done_valid, busy, req_ready,
                                aw_addr, w_data, done_status, ok_count, err_count}), 64'd0);
        rst_n   = 1'b1;
        b_valid = 1'b0;
        tick();
        chk("rst_no_done", 64'({busy, done_valid, aw_valid, w_valid, b_ready, req_ready}),
            64'(6'b000001));
        chk("rst_counts", 64'({ok_count, err_count}), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_state", 64'({aw_valid, w_valid, b_ready, done_valid, busy, req_ready,
                                aw_addr, w_data, done_status, ok_count, err_count}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        run_txn(8'h00, 32'hA500_0011, 0, 0, 2, 1'b1);
        run_txn(8'h00, 32'h1234_5678, 0, 0, 2, 1'b0);
        run_txn(8'h04, 32'hDEAD_BEEF, 5, 0, 6, 1'b1);
        run_txn(8'h00, 32'hCAFE_F00D, 0, 0, TMO + 5, 1'b1);
        run_txn(8'h04, 32'h0000_0001, 0, 0, TMO - 1, 1'b1);
        run_txn(8'h00, 32'h0000_0002, TMO + 1, 1, 2, 1'b1);
        run_txn(8'h04, 32'h0000_0003, 2, 3, 0, 1'b1);
        idle_cycles(2);
        reset_mid_txn();
        run_txn(8'h00, 32'h5555_AAAA, 1, 0, 3, 1'b1);
        for (int i = 0; i < 5; i++)
            run_txn(8'h04, $urandom, 0, 0, 1, 1'b1);

        repeat (150) begin
            run_txn(AW'($urandom_range(0, 1) * 4), $urandom,
                    $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1),
                    $urandom_range(0, TMO + 2), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
